// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin sequencing controller for a shared add-shift signed multiplier
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   req[1:0] in   per-requester job request, sampled in IDLE only
//   m        in   LSB of the datapath B register
//   gnt[1:0] out  one-hot grant, held from LOAD through DONE
//   sel      out  operand mux select (current/last granted requester)
//   done[1:0]out  one-cycle completion pulse to the granted requester
//   busy     out  high in every state except IDLE
//   clr_ax   out  clear A and X
//   ld_b     out  load B from the selected requester
//   add      out  A <= A + S
//   sub      out  A <= A - S (sign-bit iteration)
//   shift    out  arithmetic right shift of X:A:B
`timescale 1ns/1ps
module mult_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       m,
    output logic [1:0] gnt,
    output logic       sel,
    output logic [1:0] done,
    output logic       busy,
    output logic       clr_ax,
    output logic       ld_b,
    output logic       add,
    output logic       sub,
    output logic       shift
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ITER_END = CW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_OP    = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_count;
    logic            r_last;
    logic [1:0]      r_gnt;
    logic            r_sel;
    logic            w_any_req;
    logic            w_winner;
    logic [CW-1:0]   w_count_inc;
    logic            w_last_bit;

    assign w_any_req   = |req;
    // A lone request wins outright; on contention the requester that did
    // not win last time is chosen.
    assign w_winner    = (req == 2'b10) ? 1'b1 :
                         (req == 2'b01) ? 1'b0 : ~r_last;
    assign w_count_inc = r_count + 1'b1;
    assign w_last_bit  = (r_count == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any_req ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_OP;
            S_OP:    w_next = S_SHIFT;
            S_SHIFT: w_next = (w_count_inc == ITER_END) ? S_DONE : S_OP;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, select, fairness pointer and iteration counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt  <= w_winner ? 2'b10 : 2'b01;
                        r_sel  <= w_winner;
                        r_last <= w_winner;
                    end
                end
                S_LOAD:  r_count <= '0;
                S_SHIFT: r_count <= w_count_inc;
                S_DONE:  r_gnt   <= 2'b00;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt    = r_gnt;
        sel    = r_sel;
        done   = 2'b00;
        busy   = (r_state != S_IDLE);
        clr_ax = 1'b0;
        ld_b   = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        shift  = 1'b0;
        case (r_state)
            S_LOAD: begin
                clr_ax = 1'b1;
                ld_b   = 1'b1;
            end
            S_OP: begin
                // The final multiplier bit is the two's-complement sign bit,
                // so its partial product is subtracted instead of added.
                add = m & ~w_last_bit;
                sub = m & w_last_bit;
            end
            S_SHIFT: shift = 1'b1;
            S_DONE:  done  = r_gnt;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - directed self-checking bench for mult_share_ctrl
`timescale 1ns/1ps
module tb_mult_share_ctrl;

    logic       clk;
    logic       reset_n;
    logic [1:0] req;
    logic       m;
    logic [1:0] gnt;
    logic       sel;
    logic [1:0] done;
    logic       busy;
    logic       clr_ax;
    logic       ld_b;
    logic       add;
    logic       sub;
    logic       shift;
    logic [4:0] strb;

    int n_checks = 0;
    int n_fail   = 0;

    mult_share_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .m       (m),
        .gnt     (gnt),
        .sel     (sel),
        .done    (done),
        .busy    (busy),
        .clr_ax  (clr_ax),
        .ld_b    (ld_b),
        .add     (add),
        .sub     (sub),
        .shift   (shift)
    );

    assign strb = {clr_ax, ld_b, add, sub, shift};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_sel);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_gnt"},  32'(gnt),  32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_strb"}, 32'(strb), 32'd0);
        check_eq({tag, "_sel"},  32'(sel),  32'(exp_sel));
    endtask

    task automatic idle_cycles(input string tag, input int n, input logic exp_sel);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 2'b00;
            m   = 1'b1;
            #1;
            check_idle_outputs(tag, exp_sel);
        end
    endtask

    // One full job: the first cycle is the IDLE cycle T in which req is
    // sampled, then LOAD at T+1, OP/SHIFT pairs at T+2..T+17, DONE at T+18.
    // m follows b LSB-first in OP cycles and is held high elsewhere so that
    // gating of add/sub to the OP state is exercised.
    task automatic job(input string tag, input logic [1:0] rq, input logic [7:0] b,
                       input logic [1:0] exp_g, input int drop_at);
        logic [4:0] es;
        logic [1:0] ed;
        int         k;
        @(negedge clk);
        req = rq;
        m   = 1'b1;
        #1;
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == drop_at) req = 2'b00;
            m  = 1'b1;
            es = 5'b00000;
            ed = 2'b00;
            if (c == 1) begin
                es = 5'b11000;
            end else if (c == 18) begin
                ed = exp_g;
            end else if ((c % 2) == 0) begin
                k = (c - 2) / 2;
                m = b[k];
                if (b[k]) es = (k == 7) ? 5'b00010 : 5'b00100;
            end else begin
                es = 5'b00001;
            end
            #1;
            check_eq($sformatf("%s_strb_c%0d", tag, c), 32'(strb), 32'(es));
            check_eq($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(ed));
            check_eq($sformatf("%s_gnt_c%0d",  tag, c), 32'(gnt),  32'(exp_g));
            check_eq($sformatf("%s_sel_c%0d",  tag, c), 32'(sel),  32'(exp_g[1]));
            check_eq($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        req     = 2'b11;
        m       = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("rst_async", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle_outputs("rst_hold", 1'b0);
        end
        @(negedge clk);
        req     = 2'b00;
        reset_n = 1'b1;
        idle_cycles("post_rst", 10, 1'b0);

        // Continuous contention: round-robin starting at requester 0.
        job("rr0", 2'b11, 8'hFF, 2'b01, 0);
        job("rr1", 2'b11, 8'h00, 2'b10, 0);
        job("rr2", 2'b11, 8'h81, 2'b01, 18);

        job("r0_b05", 2'b01, 8'h05, 2'b01, 18);
        job("r1_b80", 2'b10, 8'h80, 2'b10, 18);
        idle_cycles("sel_keep", 3, 1'b1);

        // Request withdrawn mid-job: job still runs to completion.
        job("drop", 2'b01, 8'hA3, 2'b01, 5);
        idle_cycles("after_drop", 5, 1'b0);

        // Reset during a job aborts it with no done pulse.
        @(negedge clk);
        req = 2'b01;
        m   = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        check_eq("abort_pre_busy", 32'(busy), 32'd1);
        check_eq("abort_pre_strb", 32'(strb), 32'b00001);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort_async", 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_idle_outputs("abort_hold", 1'b0);
        end
        @(negedge clk);
        req     = 2'b00;
        reset_n = 1'b1;
        job("fresh", 2'b01, 8'h05, 2'b01, 18);
        idle_cycles("end_idle", 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencing controller for the shared add-shift 8-bit signed multiplier datapath (A, B, X registers with adder/subtractor).
- Arbitrates between two requesters with round-robin fairness and steers the winner's operands into the datapath via `sel`.
- Runs a fixed-latency add/sub/shift sequence and returns a one-cycle `done` pulse to the granted requester.
- Emits control strobes only; the datapath itself is external.

Parameters:
- WIDTH, 8, multiplier bit count (number of OP/SHIFT iterations); counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester job request; bit i = requester i.
- m  in  1  LSB of datapath B register; valid every cycle.
- gnt  out  2  one-hot grant, held from LOAD through DONE.
- sel  out  1  operand mux select, index of the current/last granted requester.
- done  out  2  one-cycle pulse on bit gnt index in the DONE state.
- busy  out  1  high in every state except IDLE.
- clr_ax  out  1  clear A and X (LOAD state).
- ld_b  out  1  load B from the selected requester's operand (LOAD state).
- add  out  1  A <= A + S (OP state, m=1, not the last bit).
- sub  out  1  A <= A - S (OP state, m=1, last bit).
- shift  out  1  arithmetic right shift of X:A:B (SHIFT state).

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; count=0; last=1, so requester 0 wins the first contention.
  - sel=0; gnt, done, busy and all strobes = 0 immediately, without waiting for clk.
- States: IDLE, LOAD, OP, SHIFT, DONE. Outputs are decoded from registered state/grant, with no combinational path from req to outputs.
- IDLE:
  - req sampled here only.
  - req=00: stay in IDLE.
  - Exactly one bit set: grant that requester.
  - req=11: grant the requester != last.
  - On a grant: gnt and sel register the winner, last <= winner, next state LOAD.
- LOAD (1 cycle): clr_ax=1, ld_b=1, count <= 0; next state OP.
- OP (1 cycle):
  - m=1 and count<WIDTH-1: add=1.
  - m=1 and count==WIDTH-1: sub=1 (two's-complement sign bit).
  - m=0: no strobe.
  - add and sub are never high together. Next state SHIFT.
- SHIFT (1 cycle): shift=1, count <= count+1.
  - If count+1 == WIDTH, next state DONE; else OP.
- DONE (1 cycle): done[gnt index]=1. Next state IDLE; gnt cleared on leaving DONE.
- Latency, fixed and data-independent:
  - Grant sampled at IDLE cycle T puts LOAD at T+1, OP/SHIFT pairs at T+2..T+2W+1, DONE at T+2W+2.
  - For W=8, DONE is at T+18.
  - Minimum one IDLE cycle between jobs.
- Handshake rules:
  - req changes during a job are ignored; the job always completes.
  - A requester must drop req in its done cycle or be re-considered in the following IDLE cycle.
- sel retains its value outside jobs.
- The strobe set {clr_ax|ld_b, add, sub, shift} is mutually exclusive in every cycle.
- reset_n asserted mid-job aborts immediately: no done pulse; the datapath state is don't-care.

Test Plan:
- Reset: reset_n=0 with arbitrary req/m -> all outputs 0, sel=0; after release with req=00, stays IDLE with busy=0 for 10 cycles.
- req=01, B=0x05 (m LSB-first 1,0,1,0,0,0,0,0) -> LOAD at T+1; add in OP iterations 0 and 2 only; no sub; 8 shift pulses; done=01 at T+18; gnt=01 and sel=0 through T+18.
- req=10, B=0x80 (m=1 only on iteration 7) -> sub pulse only in the 8th OP cycle (T+16); no add; done=10 at T+18; sel=1.
- req=11 held continuously from reset -> grants in order 01, 10, 01, each separated by exactly one IDLE cycle; done pulses alternate 01, 10, 01.
- reset_n driven low at T+7 of a job -> all outputs 0 asynchronously in that same cycle, no done pulse; after release with req=01, a fresh job completes with done at T'+18.
- req=01 dropped at T+5 -> job still completes, done=01 at T+18; next IDLE sees req=00 and stays idle.
